// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two-requester round-robin front end for one BRAM port.
// The winner is registered onto the port the cycle after acceptance. A
// {vld,id} shift register tracks reads so that bram_dout can be steered back
// to the requester that issued the read.
module bram_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int NREQ = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [NREQ-1:0]     req_vld, req_rdy, rsp_vld;
  req_t [NREQ-1:0]     req;
  req_t                sel;
  logic                last_grant, gnt_vld, gnt_id, hs;
  logic [READ_LAT:0]   vld_pipe, id_pipe;

  assign req_vld = {req1_valid, req0_valid};
  assign req[0]  = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
  assign req[1]  = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};

  // Round-robin pick: a lone requester wins; on contention the one that did not win last.
  always_comb begin
    gnt_vld = |req_vld;
    gnt_id  = req_vld[1];
    if (&req_vld) gnt_id = ~last_grant;
  end

  // The winner is always ready, so a grant outside reset is a handshake.
  assign hs  = gnt_vld & ~rst;
  assign sel = req[gnt_id];

  for (genvar n = 0; n < NREQ; n++) begin : g_req
    assign req_rdy[n] = hs && (gnt_id == 1'(n));
    // Reset masks the tail so reads in flight at reset never report.
    assign rsp_vld[n] = vld_pipe[READ_LAT] && (id_pipe[READ_LAT] == 1'(n)) && !rst;
  end

  assign req0_ready = req_rdy[0];
  assign req1_ready = req_rdy[1];
  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_data  = rsp_vld[0] ? bram_dout : '0;
  assign rsp1_data  = rsp_vld[1] ? bram_dout : '0;

  // Request stage: register the accepted request onto the BRAM port and remember the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
    end else begin
      bram_en <= hs;
      bram_we <= hs & sel.we;
      if (hs) begin
        bram_addr  <= sel.addr;
        bram_din   <= sel.wdata;
        last_grant <= gnt_id;
      end
    end
  end

  // Read tracking: stage 0 lines up with the port cycle, the last stage with bram_dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[READ_LAT-1:0], hs & ~sel.we};
      id_pipe  <= {id_pipe[READ_LAT-1:0], gnt_id};
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two DUTs (READ_LAT 2 and 1) share one stimulus
// stream, each with its own BRAM model and response scoreboard.
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, we0, v1, we1;
  logic [9:0] a0, a1;
  logic [7:0] d0, d1;

  // instance A: READ_LAT=2, instance B: READ_LAT=1
  logic       r0A, r1A, rv0A, rv1A, enA, weA;
  logic [7:0] rd0A, rd1A, dinA, doutA;
  logic [9:0] addrA;
  logic       r0B, r1B, rv0B, rv1B, enB, weB;
  logic [7:0] rd0B, rd1B, dinB, doutB;
  logic [9:0] addrB;

  bram_port_arbiter #(.ADDR_W(10), .DATA_W(8), .READ_LAT(2)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0A), .req0_addr(a0), .req0_wdata(d0), .req0_we(we0),
    .rsp0_valid(rv0A), .rsp0_data(rd0A),
    .req1_valid(v1), .req1_ready(r1A), .req1_addr(a1), .req1_wdata(d1), .req1_we(we1),
    .rsp1_valid(rv1A), .rsp1_data(rd1A),
    .bram_en(enA), .bram_we(weA), .bram_addr(addrA), .bram_din(dinA), .bram_dout(doutA));

  bram_port_arbiter #(.ADDR_W(10), .DATA_W(8), .READ_LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0B), .req0_addr(a0), .req0_wdata(d0), .req0_we(we0),
    .rsp0_valid(rv0B), .rsp0_data(rd0B),
    .req1_valid(v1), .req1_ready(r1B), .req1_addr(a1), .req1_wdata(d1), .req1_we(we1),
    .rsp1_valid(rv1B), .rsp1_data(rd1B),
    .bram_en(enB), .bram_we(weB), .bram_addr(addrB), .bram_din(dinB), .bram_dout(doutB));

  // BRAM models: read-first, 2-cycle and 1-cycle read latency
  logic [7:0] memA [1024];
  logic [7:0] memB [1024];
  logic [7:0] stA;
  always @(posedge clk) begin
    if (enA && weA) memA[addrA] <= dinA;
    if (enA) stA <= memA[addrA];
    doutA <= stA;
  end
  always @(posedge clk) begin
    if (enB && weB) memB[addrB] <= dinB;
    if (enB) doutB <= memB[addrB];
  end

  typedef struct {
    int         id;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       qA[$], qB[$];
  exp_t       eA, eB;
  logic [7:0] shadow [1024];
  int         cyc = 0;
  int         n_chk = 0, n_pass = 0;
  int         p_eg = 2;
  logic       p_we;
  logic [9:0] p_a;
  logic [7:0] p_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // monitors: pop the oldest expected read response whenever a DUT reports one
  always @(negedge clk) begin
    if (rv0A || rv1A) begin
      chk("A_rsp_exclusive", 32'(rv0A & rv1A), 0);
      if (qA.size() == 0) chk("A_rsp_unexpected", 32'(rv0A | rv1A), 0);
      else begin
        eA = qA.pop_front();
        chk("A_rsp_id", 32'(rv1A), eA.id);
        chk("A_rsp_data", 32'(rv1A ? rd1A : rd0A), 32'(eA.data));
        chk("A_rsp_cycle", cyc, eA.cyc);
      end
    end
  end
  always @(negedge clk) begin
    if (rv0B || rv1B) begin
      chk("B_rsp_exclusive", 32'(rv0B & rv1B), 0);
      if (qB.size() == 0) chk("B_rsp_unexpected", 32'(rv0B | rv1B), 0);
      else begin
        eB = qB.pop_front();
        chk("B_rsp_id", 32'(rv1B), eB.id);
        chk("B_rsp_data", 32'(rv1B ? rd1B : rd0B), 32'(eB.data));
        chk("B_rsp_cycle", cyc, eB.cyc);
      end
    end
  end

  // One cycle of stimulus; eg is the hand-computed winner (0, 1, or 2 = none).
  task automatic drive(input logic rst_,
                       input logic v0_, input logic we0_, input logic [9:0] a0_, input logic [7:0] d0_,
                       input logic v1_, input logic we1_, input logic [9:0] a1_, input logic [7:0] d1_,
                       input int eg);
    logic       swe;
    logic [9:0] sa;
    logic [7:0] sd;
    @(posedge clk);
    #1;
    rst = rst_;
    v0 = v0_; we0 = we0_; a0 = a0_; d0 = d0_;
    v1 = v1_; we1 = we1_; a1 = a1_; d1 = d1_;
    if (rst_) begin
      qA.delete();
      qB.delete();
    end
    @(negedge clk);
    chk("A_ready0", 32'(r0A), 32'(eg == 0));
    chk("A_ready1", 32'(r1A), 32'(eg == 1));
    chk("B_ready0", 32'(r0B), 32'(eg == 0));
    chk("B_ready1", 32'(r1B), 32'(eg == 1));
    if (rst_) begin
      chk("A_rst_rsp", 32'(rv0A | rv1A), 0);
      chk("B_rst_rsp", 32'(rv0B | rv1B), 0);
    end
    chk("A_bram_en", 32'(enA), 32'(p_eg != 2));
    chk("B_bram_en", 32'(enB), 32'(p_eg != 2));
    chk("A_bram_we", 32'(weA), 32'(p_eg != 2 && p_we));
    chk("B_bram_we", 32'(weB), 32'(p_eg != 2 && p_we));
    if (p_eg != 2) begin
      chk("A_bram_addr", 32'(addrA), 32'(p_a));
      chk("B_bram_addr", 32'(addrB), 32'(p_a));
      if (p_we) begin
        chk("A_bram_din", 32'(dinA), 32'(p_d));
        chk("B_bram_din", 32'(dinB), 32'(p_d));
      end
    end
    swe = (eg == 1) ? we1_ : we0_;
    sa  = (eg == 1) ? a1_  : a0_;
    sd  = (eg == 1) ? d1_  : d0_;
    if (eg != 2) begin
      if (swe) shadow[sa] = sd;
      else begin
        qA.push_back('{id: eg, data: shadow[sa], cyc: cyc + 3});
        qB.push_back('{id: eg, data: shadow[sa], cyc: cyc + 2});
      end
    end
    p_eg = eg; p_we = swe; p_a = sa; p_d = sd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
  endtask

  initial begin
    logic [9:0] wa;
    rst = 1'b1;
    v0 = 0; we0 = 0; a0 = 0; d0 = 0;
    v1 = 0; we1 = 0; a1 = 0; d1 = 0;
    // reset: both requesting, nothing granted, port idle
    drive(1, 1, 0, 10'h000, 8'h00, 1, 0, 10'h000, 8'h00, 2);
    drive(1, 1, 0, 10'h000, 8'h00, 1, 0, 10'h000, 8'h00, 2);
    chk("A_rst_addr", 32'(addrA), 0);
    chk("B_rst_din", 32'(dinB), 0);

    // 1: write 0x005=A5, read it back 4 cycles later
    drive(0, 1, 1, 10'h005, 8'hA5, 0, 0, 10'h000, 8'h00, 0);
    idle(3);
    drive(0, 1, 0, 10'h005, 8'h00, 0, 0, 10'h000, 8'h00, 0);
    idle(4);

    // 2: preload 0x010/0x020, then both read continuously, alternating from 0
    drive(0, 1, 1, 10'h010, 8'h11, 0, 0, 10'h000, 8'h00, 0);
    drive(0, 0, 0, 10'h000, 8'h00, 1, 1, 10'h020, 8'h22, 1);
    for (int i = 0; i < 6; i++)
      drive(0, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, i % 2);
    idle(4);

    // 3: req1 alone, 8 writes then 8 reads across the address wrap
    for (int i = 0; i < 8; i++) begin
      wa = 10'h3FC + 10'(i);
      drive(0, 0, 0, 10'h000, 8'h00, 1, 1, wa, 8'hC0 + 8'(i), 1);
    end
    for (int i = 0; i < 8; i++) begin
      wa = 10'h3FC + 10'(i);
      drive(0, 0, 0, 10'h000, 8'h00, 1, 0, wa, 8'h00, 1);
    end
    idle(4);

    // 4: contention with last_grant=1: req0 write wins, req1 reads new data next
    drive(0, 1, 1, 10'h100, 8'h77, 1, 0, 10'h100, 8'h00, 0);
    drive(0, 0, 0, 10'h000, 8'h00, 1, 0, 10'h100, 8'h00, 1);
    idle(4);

    // 5: two reads then reset: no responses, req0 wins first contention after
    drive(0, 1, 0, 10'h010, 8'h00, 0, 0, 10'h000, 8'h00, 0);
    drive(0, 0, 0, 10'h000, 8'h00, 1, 0, 10'h020, 8'h00, 1);
    drive(1, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, 2);
    drive(0, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, 0);
    drive(0, 1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00, 1);
    idle(5);

    chk("A_sb_drained", qA.size(), 0);
    chk("B_sb_drained", qB.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
